// File: rtl/pkt_framer_pkg.sv
// Shared types and defaults for the transmit-side packet framer.
// The optional checksum trailer is selected by the PKT_FRAMER_CHK_EN macro.
package pkt_framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_DROP = 3'd2,
        ST_HDR0 = 3'd3,
        ST_HDR1 = 3'd4,
        ST_LEN  = 3'd5,
        ST_DATA = 3'd6,
        ST_CHK  = 3'd7
    } state_e;

    localparam int         DEF_MAX_LEN = 16;
    localparam logic [7:0] DEF_HDR0    = 8'h55;
    localparam logic [7:0] DEF_HDR1    = 8'hD5;

endpackage

// File: rtl/pkt_framer_buf.sv
// Payload store for one packet: a MAX_LEN x 8 register file with one
// synchronous write port and one combinational read port.
module pkt_buf
    import pkt_framer_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int AW      = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    localparam int            IW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [AW-1:0] DEPTH = AW'(MAX_LEN);

    logic [7:0] mem [MAX_LEN];

    always_ff @(posedge clk) begin
        if (we && (waddr < DEPTH))
            mem[waddr[IW-1:0]] <= wdata;
    end

    // The read pointer legitimately reaches MAX_LEN after the last byte.
    assign rdata = (raddr < DEPTH) ? mem[raddr[IW-1:0]] : 8'h00;

endmodule

// File: rtl/pkt_framer.sv
// Packet framer: buffers one payload, then emits HDR0, HDR1, LEN, payload
// and, when PKT_FRAMER_CHK_EN is defined, a trailing XOR checksum byte.
module pkt_framer
    import pkt_framer_pkg::*;
#(
    parameter int         MAX_LEN = DEF_MAX_LEN,
    parameter logic [7:0] HDR0    = DEF_HDR0,
    parameter logic [7:0] HDR1    = DEF_HDR1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       din_vld,
    input  logic       din_sop,
    input  logic       din_eop,
    output logic       din_rdy,
    output logic [7:0] dout,
    output logic       dout_vld,
    output logic       dout_sop,
    output logic       dout_eop,
    input  logic       dout_rdy,
    output logic       err
);

    localparam int            AW      = $clog2(MAX_LEN + 1);
    localparam logic [AW-1:0] CNT_ONE = AW'(1);
    localparam logic [AW-1:0] CNT_MAX = AW'(MAX_LEN);

    localparam logic [2:0] S_IDLE = ST_IDLE;
    localparam logic [2:0] S_LOAD = ST_LOAD;
    localparam logic [2:0] S_DROP = ST_DROP;
    localparam logic [2:0] S_HDR0 = ST_HDR0;
    localparam logic [2:0] S_HDR1 = ST_HDR1;
    localparam logic [2:0] S_LEN  = ST_LEN;
    localparam logic [2:0] S_DATA = ST_DATA;
`ifdef PKT_FRAMER_CHK_EN
    localparam logic [2:0] S_CHK  = ST_CHK;
`endif

    logic [2:0]    state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt, cnt_inc;
    logic [AW-1:0] rd_ptr, rd_nxt, rd_inc;
    logic [7:0]    dout_nxt;
    logic          vld_nxt, sop_nxt, eop_nxt, err_nxt, rdy_nxt;
    logic          acc, xfer, start;
    logic          we;
    logic [AW-1:0] waddr;
    logic [7:0]    rdata;
`ifdef PKT_FRAMER_CHK_EN
    logic [7:0]    chk, chk_nxt;
`endif

    assign acc     = din_vld && din_rdy;
    assign xfer    = dout_vld && dout_rdy;
    assign cnt_inc = cnt + CNT_ONE;
    assign rd_inc  = rd_ptr + CNT_ONE;

    // A new sop always lands in slot 0, whether it opens or restarts a packet.
    always_comb begin
        we    = 1'b0;
        waddr = '0;
        if (acc) begin
            if (state == S_IDLE) begin
                we = din_sop;
            end else if (state == S_LOAD) begin
                we    = 1'b1;
                waddr = din_sop ? '0 : cnt;
            end
        end
    end

    pkt_buf #(
        .MAX_LEN (MAX_LEN),
        .AW      (AW)
    ) u_buf (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (din),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rd_nxt    = rd_ptr;
        dout_nxt  = dout;
        vld_nxt   = dout_vld;
        sop_nxt   = dout_sop;
        eop_nxt   = dout_eop;
        err_nxt   = 1'b0;
        start     = 1'b0;
`ifdef PKT_FRAMER_CHK_EN
        chk_nxt   = chk;
`endif
        case (state)
            S_IDLE: begin
                if (acc) begin
                    if (din_sop) begin
                        cnt_nxt = CNT_ONE;
                        if (din_eop) begin
                            start = 1'b1;
                        end else if (CNT_ONE == CNT_MAX) begin
                            err_nxt   = 1'b1;
                            state_nxt = S_DROP;
                        end else begin
                            state_nxt = S_LOAD;
                        end
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (acc) begin
                    if (din_sop) begin
                        cnt_nxt = CNT_ONE;
                        err_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                    if (din_eop) begin
                        start = 1'b1;
                    end else if (cnt_nxt == CNT_MAX) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_DROP;
                    end
                end
            end
            S_DROP: begin
                if (acc && din_eop)
                    start = 1'b1;
            end
            S_HDR0: begin
                if (xfer) begin
                    state_nxt = S_HDR1;
                    dout_nxt  = HDR1;
                    sop_nxt   = 1'b0;
                end
            end
            S_HDR1: begin
                if (xfer) begin
                    state_nxt = S_LEN;
                    dout_nxt  = 8'(cnt);
                    rd_nxt    = '0;
`ifdef PKT_FRAMER_CHK_EN
                    chk_nxt   = 8'(cnt);
`endif
                end
            end
            S_LEN: begin
                if (xfer) begin
                    state_nxt = S_DATA;
                    dout_nxt  = rdata;
                    rd_nxt    = rd_inc;
`ifdef PKT_FRAMER_CHK_EN
                    chk_nxt   = chk ^ rdata;
`else
                    eop_nxt   = (cnt == CNT_ONE);
`endif
                end
            end
            S_DATA: begin
                if (xfer) begin
                    if (rd_ptr == cnt) begin
`ifdef PKT_FRAMER_CHK_EN
                        state_nxt = S_CHK;
                        dout_nxt  = chk;
                        eop_nxt   = 1'b1;
`else
                        state_nxt = S_IDLE;
                        vld_nxt   = 1'b0;
                        eop_nxt   = 1'b0;
`endif
                    end else begin
                        dout_nxt = rdata;
                        rd_nxt   = rd_inc;
`ifdef PKT_FRAMER_CHK_EN
                        chk_nxt  = chk ^ rdata;
`else
                        eop_nxt  = (rd_inc == cnt);
`endif
                    end
                end
            end
`ifdef PKT_FRAMER_CHK_EN
            S_CHK: begin
                if (xfer) begin
                    state_nxt = S_IDLE;
                    vld_nxt   = 1'b0;
                    eop_nxt   = 1'b0;
                end
            end
`endif
            default: begin
                state_nxt = S_IDLE;
                vld_nxt   = 1'b0;
                sop_nxt   = 1'b0;
                eop_nxt   = 1'b0;
            end
        endcase
        // The HDR0 byte is presented in the same edge that accepts the last input byte.
        if (start) begin
            state_nxt = S_HDR0;
            dout_nxt  = HDR0;
            vld_nxt   = 1'b1;
            sop_nxt   = 1'b1;
            eop_nxt   = 1'b0;
        end
    end

    assign rdy_nxt = (state_nxt == S_IDLE) || (state_nxt == S_LOAD) || (state_nxt == S_DROP);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rd_ptr   <= '0;
            din_rdy  <= 1'b0;
            dout     <= 8'h00;
            dout_vld <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
            err      <= 1'b0;
`ifdef PKT_FRAMER_CHK_EN
            chk      <= 8'h00;
`endif
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rd_ptr   <= rd_nxt;
            din_rdy  <= rdy_nxt;
            dout     <= dout_nxt;
            dout_vld <= vld_nxt;
            dout_sop <= sop_nxt;
            dout_eop <= eop_nxt;
            err      <= err_nxt;
`ifdef PKT_FRAMER_CHK_EN
            chk      <= chk_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_pkt_framer.sv
// Self-checking bench for pkt_framer (MAX_LEN=4): table vectors, corner
// sequences and randomized packets against a frame-level reference model.
module tb_pkt_framer;

    localparam int         MAXL = 4;
    localparam logic [7:0] H0   = 8'h55;
    localparam logic [7:0] H1   = 8'hD5;

    logic       clk = 1'b0;
    logic       rst_n, din_vld, din_sop, din_eop, din_rdy;
    logic       dout_vld, dout_sop, dout_eop, dout_rdy, err;
    logic [7:0] din, dout;

    always #5 clk = ~clk;

    pkt_framer #(.MAX_LEN(MAXL)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
        .din_sop(din_sop), .din_eop(din_eop), .din_rdy(din_rdy),
        .dout(dout), .dout_vld(dout_vld), .dout_sop(dout_sop),
        .dout_eop(dout_eop), .dout_rdy(dout_rdy), .err(err)
    );

    int checks = 0, errors = 0, err_seen = 0;
    int obs_base = 0, err_base = 0;
    logic [9:0] obs_q[$];   // {sop, eop, byte}
    logic [9:0] exp_q[$];

    typedef struct {
        int               n;
        logic [0:7][7:0]  pl;
        logic [0:11][7:0] fr;
        int               nfr;
        int               nerr;
    } vec_t;
    vec_t tbl[5];

    always @(negedge clk) begin
        if (dout_vld && dout_rdy) obs_q.push_back({dout_sop, dout_eop, dout});
        if (err) err_seen++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
        end
    endtask

    task automatic mark();
        obs_base = obs_q.size();
        err_base = err_seen;
    endtask

    // Without the checksum trailer the frame ends on the last payload byte.
    task automatic trim_chk();
`ifndef PKT_FRAMER_CHK_EN
        logic [9:0] last;
        void'(exp_q.pop_back());
        last = exp_q.pop_back();
        exp_q.push_back(last | 10'h100);
`endif
    endtask

    task automatic make_exp(input logic [7:0] pl[$]);
        int n;
        logic [7:0] x;
        n = (pl.size() > MAXL) ? MAXL : pl.size();
        x = 8'(n);
        exp_q = {};
        exp_q.push_back({2'b10, H0});
        exp_q.push_back({2'b00, H1});
        exp_q.push_back({2'b00, 8'(n)});
        for (int i = 0; i < n; i++) begin
            x = x ^ pl[i];
            exp_q.push_back({2'b00, pl[i]});
        end
        exp_q.push_back({2'b01, x});
        trim_chk();
    endtask

    task automatic put(input logic [9:0] b);
        bit ok = 0;
        din = b[7:0]; din_sop = b[9]; din_eop = b[8]; din_vld = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (din_rdy) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (ok) begin @(posedge clk); #1; end
        din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL din_rdy timeout actual=0 expected=1");
        end
    endtask

    task automatic wait_frame(input bit bp);
        bit done = 0;
        for (int i = 0; i < 300; i++) begin
            dout_rdy = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            done = dout_vld && dout_rdy && dout_eop;
            @(posedge clk); #1;
            if (done) break;
        end
        dout_rdy = 1'b1;
        if (!done) begin
            checks++; errors++;
            $display("FAIL frame timeout actual=no_eop expected=eop");
        end
    endtask

    task automatic cmp_frame(input string nm, input int exp_err);
        int nobs, bad;
        nobs = obs_q.size() - obs_base;
        bad = -1;
        check({nm, " frame_len"}, nobs, exp_q.size());
        for (int i = 0; i < nobs && i < exp_q.size(); i++)
            if (bad < 0 && obs_q[obs_base+i] !== exp_q[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s byte%0d actual=%h expected=%h (sop,eop,byte)",
                     nm, bad, obs_q[obs_base+bad], exp_q[bad]);
        end
        check({nm, " err_count"}, err_seen - err_base, exp_err);
    endtask

    initial begin
        logic [7:0] q[$];
        int n, stray, v;

        tbl[0] = '{3, {8'h01, 8'h02, 8'h03, 40'h0},
                   {8'h55, 8'hD5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h03, 40'h0}, 7, 0};
        tbl[1] = '{1, {8'hAA, 56'h0},
                   {8'h55, 8'hD5, 8'h01, 8'hAA, 8'hAB, 56'h0}, 5, 0};
        tbl[2] = '{6, {8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 16'h0},
                   {8'h55, 8'hD5, 8'h04, 8'h10, 8'h11, 8'h12, 8'h13, 8'h04, 32'h0}, 8, 1};
        tbl[3] = '{4, {8'h00, 8'hFF, 8'h80, 8'h7F, 32'h0},
                   {8'h55, 8'hD5, 8'h04, 8'h00, 8'hFF, 8'h80, 8'h7F, 8'h04, 32'h0}, 8, 0};
        tbl[4] = '{2, {8'h5A, 8'hA5, 48'h0},
                   {8'h55, 8'hD5, 8'h02, 8'h5A, 8'hA5, 8'hFD, 48'h0}, 6, 0};

        rst_n = 1'b1; din = 8'h00; din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
        dout_rdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset outputs", {din_rdy, dout, dout_vld, dout_sop, dout_eop, err}, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("din_rdy first cycle after reset", din_rdy, 0);
        @(negedge clk);
        check("din_rdy second cycle after reset", din_rdy, 1);
        @(posedge clk); #1;

        for (int k = 0; k < 5; k++) begin
            mark();
            for (int i = 0; i < tbl[k].n; i++)
                put({1'(i == 0), 1'(i == tbl[k].n - 1), tbl[k].pl[i]});
            wait_frame(0);
            exp_q = {};
            for (int i = 0; i < tbl[k].nfr; i++)
                exp_q.push_back({1'(i == 0), 1'(i == tbl[k].nfr - 1), tbl[k].fr[i]});
            trim_chk();
            cmp_frame($sformatf("table%0d", k), tbl[k].nerr);
        end

        // single-beat packet: frame starts the cycle after the sop&eop beat
        mark();
        din = 8'hAA; din_sop = 1'b1; din_eop = 1'b1; din_vld = 1'b1;
        @(negedge clk);
        check("single accept cycle {vld,rdy}", {dout_vld, din_rdy}, 2'b01);
        @(posedge clk); #1;
        din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
        @(negedge clk);
        check("single next cycle {vld,sop,dout}", {dout_vld, dout_sop, dout}, {2'b11, H0});
        @(posedge clk); #1;
        wait_frame(0);
        q = {8'hAA}; make_exp(q);
        cmp_frame("single", 0);

        // overflow: err exactly one cycle after the MAX_LEN-th byte
        mark();
        put({2'b10, 8'h10}); put({2'b00, 8'h11}); put({2'b00, 8'h12}); put({2'b00, 8'h13});
        @(negedge clk);
        check("overflow err pulse", err, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("overflow err one cycle", err, 0);
        @(posedge clk); #1;
        put({2'b00, 8'h14}); put({2'b01, 8'h15});
        wait_frame(0);
        q = {8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15}; make_exp(q);
        cmp_frame("overflow", 1);

        // backpressure: stall three cycles while 02 is presented
        mark();
        put({2'b10, 8'h01}); put({2'b00, 8'h02}); put({2'b01, 8'h03});
        v = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dout_vld && dout == 8'h01) begin v = 1; break; end
            @(posedge clk); #1;
        end
        check("bp found payload 01", v, 1);
        @(posedge clk); #1;
        dout_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("bp hold%0d {vld,din_rdy,dout}", i), {dout_vld, din_rdy, dout}, {2'b10, 8'h02});
            @(posedge clk); #1;
        end
        dout_rdy = 1'b1;
        @(negedge clk);
        check("bp release {vld,dout}", {dout_vld, dout}, {1'b1, 8'h02});
        @(posedge clk); #1;
        wait_frame(0);
        q = {8'h01, 8'h02, 8'h03}; make_exp(q);
        cmp_frame("backpressure", 0);

        // stray byte in IDLE, then a second sop in the middle of a packet
        mark();
        put({2'b00, 8'h77});
        @(negedge clk);
        check("stray err pulse", err, 1);
        v = 0;
        repeat (5) begin @(negedge clk); v += int'(dout_vld); end
        check("stray no output", v, 0);
        @(posedge clk); #1;
        put({2'b10, 8'h21}); put({2'b00, 8'h22}); put({2'b10, 8'h31});
        @(negedge clk);
        check("restart err pulse", err, 1);
        @(posedge clk); #1;
        put({2'b01, 8'h32});
        wait_frame(0);
        q = {8'h31, 8'h32}; make_exp(q);
        cmp_frame("sop_restart", 2);

        // reset in the middle of the payload
        put({2'b10, 8'h01}); put({2'b00, 8'h02}); put({2'b01, 8'h03});
        v = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dout_vld && dout == 8'h01) begin v = 1; break; end
            @(posedge clk); #1;
        end
        check("rst found payload 01", v, 1);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid-frame reset outputs", {din_rdy, dout, dout_vld, dout_sop, dout_eop, err}, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        mark();
        put({2'b11, 8'h07});
        wait_frame(0);
        q = {8'h07}; make_exp(q);
        cmp_frame("after_reset", 0);

        // randomized packets with gaps, stray bytes and output backpressure
        for (int p = 0; p < 40; p++) begin
            q = {};
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            stray = ($urandom_range(0, 4) == 0) ? 1 : 0;
            mark();
            make_exp(q);
            if (stray != 0) put({1'b0, 1'($urandom), 8'($urandom)});
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                put({1'(i == 0), 1'(i == n - 1), q[i]});
            end
            wait_frame(1);
            cmp_frame($sformatf("rand%0d", p), stray + ((n > MAXL) ? 1 : 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pkt_framer.md
# pkt_framer

Transmit-side packet framer: accepts a payload byte stream delimited by `din_sop`/`din_eop` and emits a framed byte stream. The frame is two header bytes, a length byte, the payload and an optional XOR checksum, with `dout_sop`/`dout_eop`/`dout_vld` markers. It sits ahead of the line interface and is the counterpart of the stream-parsing `fsm` receiver that recovers payload from such frames. The whole packet is buffered before transmission because the length byte precedes the payload.

## Interface
- `MAX_LEN`, 16: payload buffer depth in bytes; also the maximum payload length. Range 1..255.
- `HDR0`, 8'h55: first header byte.
- `HDR1`, 8'hD5: second header byte.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset. Synchronous, active-high: `rst_n`=1 at a rising edge resets the block.
- `din` input 8: payload byte.
- `din_vld` input 1: `din` valid.
- `din_sop` input 1: first payload byte; qualified by `din_vld`.
- `din_eop` input 1: last payload byte; qualified by `din_vld`.
- `din_rdy` output 1: block accepts `din`. A byte transfers when `din_vld && din_rdy`.
- `dout` output 8: framed output byte.
- `dout_vld` output 1: `dout` valid.
- `dout_sop` output 1: marks the `HDR0` byte.
- `dout_eop` output 1: marks the last byte of the frame.
- `dout_rdy` input 1: downstream accepts. A byte transfers when `dout_vld && dout_rdy`.
- `err` output 1: one-cycle pulse on a framing error.

## Operation
States: IDLE, LOAD, DROP, HDR0, HDR1, LEN, DATA, CHK.

- **IDLE**
  - `din_rdy`=1.
  - An accepted byte with `din_sop` is written to buffer[0] and sets cnt=1.
  - If that byte also has `din_eop`, go to HDR0. Otherwise go to LOAD.
  - An accepted byte without `din_sop` is discarded and pulses `err`.
- **LOAD**
  - `din_rdy`=1. Each accepted byte is written to buffer[cnt] and cnt increments.
  - Byte with `din_eop`: go to HDR0.
  - Byte with `din_sop`: restart. Discard the buffer, store this byte at [0], set cnt=1, pulse `err`.
  - cnt reaches `MAX_LEN` without `din_eop`: pulse `err` and go to DROP. The frame is sent truncated to `MAX_LEN` bytes.
- **DROP**
  - `din_rdy`=1. Accepted bytes are discarded.
  - The accepted byte carrying `din_eop` moves the FSM to HDR0.
- **HDR0 → HDR1 → LEN → DATA → CHK**
  - `din_rdy`=0 throughout transmission.
  - Each state advances only on an output transfer.
  - Output bytes in order: `HDR0`, `HDR1`, `LEN`=cnt, buffer[0..cnt-1], then the checksum.
  - Checksum = `LEN` XOR all payload bytes sent.
  - The transfer of the `dout_eop` byte returns the FSM to IDLE.
- **Arithmetic**
  - cnt and the read index are `$clog2(MAX_LEN+1)` bits wide.
  - `LEN` is zero-extended to 8 bits.
  - Checksum is an 8-bit running XOR over `LEN` and the payload.

## Timing
- **Reset values:** state=IDLE, cnt=0, `din_rdy`=0, `dout`=8'h00, `dout_vld`=0, `dout_sop`=0, `dout_eop`=0, `err`=0. `din_rdy` rises the cycle after reset deasserts.
- **Output registers:** `dout`, `dout_vld`, `dout_sop` and `dout_eop` are registered.
- **Frame start:** `dout_vld` rises in the cycle after the terminating input byte is accepted. A single-byte packet follows the same rule: `dout_vld` rises the cycle after the `sop&eop` beat.
- **Throughput:** one output byte per cycle while `dout_rdy`=1.
- **Backpressure:** while `dout_vld && !dout_rdy`, `dout` and all markers hold stable.
- **`err`:** registered; high for exactly one cycle, the cycle after the offending transfer.
- **Reset mid-frame:** aborts immediately. No partial tail is emitted, and the next frame starts with `HDR0`.

## Configuration
- **`PKT_FRAMER_CHK_EN` defined:** the CHK state exists, and `dout_eop` marks the checksum byte.
- **`PKT_FRAMER_CHK_EN` undefined:** the CHK state and the XOR register are removed. `dout_eop` marks the last payload byte, and the frame is `LEN`+3 bytes.

## Structure
- **Package `pkt_framer_pkg`:** state enum, default `HDR0`/`HDR1` constants, default `MAX_LEN`.
- **Sub-module `pkt_buf`:** a `MAX_LEN`×8 register buffer.
  - One synchronous write port.
  - One asynchronous read port indexed by the DATA-state read pointer.
- **Top level:** the FSM, counters, checksum and output registers live in `pkt_framer`.

## Test plan
- **Basic frame:** payload 01,02,03 (sop on 01, eop on 03), `dout_rdy`=1 → `dout` 55,D5,03,01,02,03,03. `dout_sop` on 55, `dout_eop` on the final 03, `err`=0.
- **Single byte:** AA with `sop&eop` in one beat → 55,D5,01,AA,AB. `dout_vld` rises the cycle after the input beat.
- **Overflow:** `MAX_LEN`=4, payload 10..15 → one `err` pulse on accepting byte 13. Output is 55,D5,04,10,11,12,13,04, and bytes 14 and 15 are dropped.
- **Backpressure:** basic frame with `dout_rdy` low for 3 cycles while `dout`=02 → `dout`=02 and `dout_vld`=1 held for 3 cycles. The sequence is unchanged and `din_rdy`=0 throughout.
- **Error inputs:** a byte without sop in IDLE → `err` pulse, no output. A second sop mid-LOAD → `err` pulse, and only the new packet is framed.
- **Reset mid-DATA:** `rst_n`=1 while `dout`=01 → all outputs at reset values next cycle. A subsequent packet 07 (`sop&eop`) → 55,D5,01,07,06.
